// File: rtl/accumulator_dump.sv
// accumulator_dump
// Reads a window of the accumulator RAM once an accumulation pass has finished
// and streams the words out on a valid/ready interface. When clear_en is set,
// each location is overwritten with zero after its data has come back, so the
// next pass starts from zero.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   start               single-cycle dump request, only sampled in IDLE
//   base_addr, length   window start and word count (0..2^ADDR_WIDTH)
//   clear_en            zero each location after it has been read
//   busy, done          busy while dumping; done is a one-cycle completion pulse
//   rd_en, rd_addr      accumulator read port (read data one cycle later)
//   rd_rdata            accumulator read data
//   wr_en, wr_we        accumulator write port enable and strobe (always equal)
//   wr_addr, wr_wdata   clear address; write data is always zero
//   wr_mode             accumulator mode, always 0 (overwrite)
//   m_valid, m_ready    output stream handshake
//   m_data, m_last      output stream word and end-of-dump marker
//
// State table
//   IDLE  | waiting for start
//   RUN   | issuing reads while the output buffer has room
//   DRAIN | all reads issued, waiting for the last beat to be accepted
//   DONE  | one-cycle done pulse
module accumulator_dump #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 64,
  parameter int FIFO_DEPTH = 2   // two-entry buffer; other depths unsupported
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic                  clear_en,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_rdata,
  output logic                  wr_en,
  output logic                  wr_we,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_wdata,
  output logic                  wr_mode,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH:0]   remaining_q;
  logic                  clr_q;

  // Tracking for the read whose data arrives in the current cycle.
  logic                  inflight_q;
  logic [ADDR_WIDTH-1:0] inflight_addr_q;
  logic                  inflight_last_q;

  logic [DATA_WIDTH-1:0] fifo_data [2];
  logic                  fifo_last [2];
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic [1:0]            fifo_count_q;

  logic                  pop;
  logic                  push;
  logic [2:0]            occupancy;

  assign m_valid = (fifo_count_q != 2'd0);
  assign pop     = m_valid & m_ready;
  assign push    = inflight_q;

  // Credit check: words buffered after this cycle's pop, plus the read already
  // in flight, must leave a free slot for the read issued now.
  assign occupancy = {1'b0, fifo_count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign rd_en     = (state_q == S_RUN) && (remaining_q != '0) &&
                     (occupancy < 3'(FIFO_DEPTH));
  assign rd_addr   = addr_q;

  assign wr_en    = inflight_q & clr_q;
  assign wr_we    = wr_en;
  assign wr_addr  = inflight_addr_q;
  assign wr_wdata = '0;
  assign wr_mode  = 1'b0;

  assign m_data = fifo_data[rd_ptr_q];
  // The last flag of a drained entry is stale, so it is qualified by valid.
  assign m_last = fifo_last[rd_ptr_q] & m_valid;

  assign busy = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done = (state_q == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (length != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        if (rd_en && (remaining_q == 1)) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // The flagged word is the final one, so accepting it leaves the
        // buffer empty with no read in flight.
        if (pop && m_last) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q          <= '0;
      remaining_q     <= '0;
      clr_q           <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_addr_q <= '0;
      inflight_last_q <= 1'b0;
      wr_ptr_q        <= 1'b0;
      rd_ptr_q        <= 1'b0;
      fifo_count_q    <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
        fifo_last[i] <= 1'b0;
      end
    end else begin
      if ((state_q == S_IDLE) && start && (length != '0)) begin
        addr_q      <= base_addr;
        remaining_q <= length;
        clr_q       <= clear_en;
      end else if (rd_en) begin
        addr_q      <= addr_q + 1'b1;
        remaining_q <= remaining_q - 1'b1;
      end

      inflight_q <= rd_en;
      if (rd_en) begin
        inflight_addr_q <= addr_q;
        inflight_last_q <= (remaining_q == 1);
      end

      if (push) begin
        fifo_data[wr_ptr_q] <= rd_rdata;
        fifo_last[wr_ptr_q] <= inflight_last_q;
        wr_ptr_q            <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      fifo_count_q <= fifo_count_q + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: doc/accumulator_dump.md
Name: accumulator_dump

Overview:
- Drains a window of the accumulator's RAM after an accumulation pass completes.
- Sweeps an address range through the accumulator read port (1-cycle latency) and streams the words out on a valid/ready interface.
- When clear_en is set, each location is zeroed through the accumulator write port in overwrite mode, so the next pass starts from zero.
- Sits directly downstream of the accumulator and feeds the packing/output stage.

Parameters:
ADDR_WIDTH, 9, accumulator RAM address width
DATA_WIDTH, 64, accumulator word width
FIFO_DEPTH, 2, output buffer entries; fixed at 2, other values unsupported

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
start  input  1  single-cycle dump request, sampled when idle
base_addr  input  ADDR_WIDTH  first address, latched on start
length  input  ADDR_WIDTH+1  word count, 0..2^ADDR_WIDTH, latched on start
clear_en  input  1  zero each location after it is read, latched on start
busy  output  1  high from cycle after accepted start until done
done  output  1  one-cycle completion pulse
rd_en  output  1  accumulator read-port enable
rd_addr  output  ADDR_WIDTH  accumulator read-port address
rd_rdata  input  DATA_WIDTH  accumulator read data, valid cycle after rd_en
wr_en  output  1  accumulator write-port enable
wr_we  output  1  write strobe, equals wr_en
wr_addr  output  ADDR_WIDTH  clear address
wr_wdata  output  DATA_WIDTH  always 0
wr_mode  output  1  accumulator mode, always 0 (overwrite)
m_valid  output  1  stream data valid
m_ready  input  1  stream consumer ready
m_data  output  DATA_WIDTH  stream data
m_last  output  1  marks final word of the dump

Behaviour:
- Reset: clk is the only clock; rst is asynchronous and active-high. Reset clears all outputs to 0, returns the FSM to IDLE, empties the FIFO and clears the in-flight flag.
- FSM states:
  - IDLE: start=1 and length>0 → RUN; latch base_addr, length, clear_en. start=1 and length=0 → DONE, with no reads issued.
  - RUN: issues reads. When the last address has been issued → DRAIN.
  - DRAIN: waits until the FIFO is empty and no read is in flight, with the last beat accepted → DONE.
  - DONE: done=1 for one cycle → IDLE.
- start is ignored in every state except IDLE.
- Address generation: rd_addr = base_addr + issued count, modulo 2^ADDR_WIDTH, so the sweep wraps past the top of RAM.
- Read issue: rd_en=1 when in RUN, remaining>0, and (fifo_count − pop + inflight) < 2, where pop = m_valid & m_ready. rd_en is combinational from registered state and m_ready; this path is permitted.
- inflight is a flag equal to rd_en registered.
- Capture: in the cycle after rd_en (inflight=1), rd_rdata is pushed into the FIFO at the clock edge. The FIFO never overflows, by the credit rule above.
- Latency, from start sampled at edge 0:
  - rd_en high in cycle 1.
  - rdata valid in cycle 2.
  - m_valid high in cycle 3.
  - With m_ready held at 1, one word per cycle, back to back.
- Stream rules:
  - m_data and m_last hold stable while m_valid=1 and m_ready=0.
  - m_valid is never retracted without a handshake.
  - m_last=1 only on word number length.
- Clear:
  - If clear_en is latched, wr_en=wr_we=1 with wr_addr = the address whose data is being captured, in the capture cycle (one cycle after the matching rd_en).
  - wr_wdata=0 and wr_mode=0.
  - Clears never coincide with the same-address read, because the read has already returned.
  - If clear_en=0, wr_en stays 0 for the whole dump.
- length = 2^ADDR_WIDTH: the whole RAM is dumped and the last address is base_addr−1.
- done: pulses the cycle after the m_last handshake, or the cycle after start when length=0. busy drops in the same cycle done pulses.
- Reset mid-dump: the dump is abandoned with no further reads, writes or beats. Locations already cleared stay cleared. A new start behaves as from power-up.

Test Plan:
- Preload 0x10..0x13 with 1,2,3,4 via the accumulator; start base=0x10, len=4, clear_en=0, m_ready=1 → m_data 1,2,3,4 on consecutive cycles, m_last on the 4th beat, done one cycle later; readback of 0x10..0x13 is still 1,2,3,4.
- Same preload, clear_en=1 → same stream; four wr_en pulses to 0x10..0x13 with wdata=0 and mode=0; readback gives 0,0,0,0; a subsequent accumulate of 7 at 0x10 reads back 7.
- Dump of 8 words with m_ready toggling 1,0,1,0… → all 8 values in order with no loss or duplication; m_data stable during stalls; at most 2 unaccepted words plus in-flight reads at any time.
- base=0x1FE, len=4 → rd_addr sequence 0x1FE, 0x1FF, 0x000, 0x001; data matches preload.
- len=0 → no rd_en, done pulse one cycle after start, busy never set. A start pulse while busy during a 4-word dump → ignored, exactly 4 beats delivered.
- rst asserted after the 2nd beat of a 6-word dump → all outputs 0 immediately; new start base=0x20, len=2 → correct 2-word stream and done.
